leaf_out_arbiter: RTL

- Shares one leaf_interface user-to-interface output port between NUM_REQ operator output streams. Each stream is an HLS-style 32-bit TDATA/TVALID/TREADY stream.
- Round-robin grant with bounded bursts, and one registered output stage feeding din_leaf_user2interface / vld_user2interface / ack_interface2user.
- Sits between several operator instances and a single leaf_interface port inside a page top.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/leaf_out_arbiter_rr_pick.sv | 40 ++++
 rtl/leaf_out_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for page-level output arbiters: FSM encoding, clog2 helper
// and the default stream payload width.
package arb_pkg;

  localparam int DEF_PAYLOAD_BITS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational round-robin first-one search: scans req starting just after
// rr_ptr, wrapping modulo N, and returns the winner one-hot and as an index.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W:0]   s;
  logic [IDX_W-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    s       = '0;
    idx     = '0;
    any     = |req;
    // rr_ptr <= N-1 and k <= N, so one conditional subtract is enough to wrap
    for (int k = 1; k <= N; k++) begin
      s = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
      idx = s[IDX_W-1:0];
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one leaf_interface output port
// between NUM_REQ streams. Optional counters enabled with `define ARB_STATS_EN.
module leaf_out_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int MAX_BURST    = 16
) (
  input  logic                            clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            dout_vld,
  input  logic                            dout_ack,
`ifdef ARB_STATS_EN
  output logic [31:0]                     stat_beats,
  output logic [NUM_REQ*16-1:0]           stat_grants,
`endif
  output logic [NUM_REQ-1:0]              grant
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);

  arb_state_e state, state_nxt;

  logic [NUM_REQ-1:0][PAYLOAD_BITS-1:0] req_data_a;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [NUM_REQ-1:0]      grant_q;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        beat_cnt;
  logic [PAYLOAD_BITS-1:0] dout_q;
  logic                    dout_vld_q;

  logic                    g_vld;
  logic [PAYLOAD_BITS-1:0] g_data;
  logic                    out_ready;
  logic                    can_acc;
  logic                    burst_last;
  logic                    accept;
  logic                    grant_take;
  logic                    grant_drop;
  logic [NUM_REQ-1:0]      req_ack_c;

  assign req_data_a = req_data;
  assign g_vld      = req_vld[grant_idx];
  assign g_data     = req_data_a[grant_idx];
  assign out_ready  = !dout_vld_q || dout_ack;
  assign burst_last = (beat_cnt == CNT_W'(MAX_BURST - 1));

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_vld),
    .rr_ptr  (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // req_ack is combinational from dout_ack so the output stage streams 1 beat/cycle
  always_comb begin
    state_nxt  = state;
    req_ack_c  = '0;
    can_acc    = 1'b0;
    accept     = 1'b0;
    grant_take = 1'b0;
    grant_drop = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_take = 1'b1;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        can_acc              = out_ready && (beat_cnt < CNT_W'(MAX_BURST));
        req_ack_c[grant_idx] = can_acc;
        accept               = can_acc && g_vld;
        if ((accept && burst_last) || (can_acc && !g_vld)) begin
          grant_drop = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      grant_q    <= '0;
      grant_idx  <= '0;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      if (grant_take) begin
        grant_q   <= pick_oh;
        grant_idx <= pick_idx;
        rr_ptr    <= pick_idx;
        beat_cnt  <= '0;
      end else if (grant_drop) begin
        grant_q <= '0;
      end
      // output register keeps draining after the grant is released
      if (accept) begin
        dout_q     <= g_data;
        dout_vld_q <= 1'b1;
        beat_cnt   <= beat_cnt + CNT_W'(1);
      end else if (dout_vld_q && dout_ack) begin
        dout_vld_q <= 1'b0;
      end
    end
  end

  assign req_ack  = req_ack_c;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign grant    = grant_q;

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;

  always_ff @(posedge clk) begin
    if (!ap_rst_n)                  stat_beats <= '0;
    else if (dout_vld_q && dout_ack) stat_beats <= stat_beats + 32'd1;
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    always_ff @(posedge clk) begin
      if (!ap_rst_n)
        grant_cnt[g] <= '0;
      else if (grant_take && pick_oh[g] && (grant_cnt[g] != 16'hFFFF))
        grant_cnt[g] <= grant_cnt[g] + 16'd1;
    end
  end

  assign stat_grants = grant_cnt;
`endif

endmodule
